wb_sdr_traffic_gen: RTL and testbench

- Parametrised Wishbone B3 master that generates self-checking traffic against the SDRAM controller's Wishbone slave port.
- Writes N bursts of a data pattern from a base address, then re-reads the same region and compares each beat.
- Generalises data width, burst length and pattern over the fixed 8-bit single-pattern stimulus in the current bench.
- Sits in place of the bench's procedural Wishbone driver; it can also be instantiated on-chip as a BIST source.

---
 rtl/tg_pkg.sv | 33 +++
 rtl/tg_pattern_gen.sv | 41 ++++
 rtl/wb_sdr_traffic_gen.sv | 197 +++++++++++++++++++
 tb/tb_wb_sdr_traffic_gen.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tg_pkg.sv
// ==================================================================
// tg_pkg : shared types and constants for the Wishbone traffic generator
// Rev 1.0
// ==================================================================
`timescale 1ns/1ps
`default_nettype none

package tg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    WR_GAP = 3'd2,
    RD     = 3'd3,
    RD_GAP = 3'd4,
    DONE   = 3'd5
  } tg_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;

  // Right-shifting Galois step: taps are folded in when the bit shifted out is 1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tg_pattern_gen.sv
// ==================================================================
// tg_pattern_gen : incrementing / LFSR data source, reloaded per phase
// Rev 1.0
// ==================================================================
`timescale 1ns/1ps
`default_nettype none

module tg_pattern_gen
  import tg_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mode,
  input  logic          load,
  input  logic          advance,
  output logic [DW-1:0] value
);

  logic [31:0] cnt_q;
  logic [31:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 32'd0;
      lfsr_q <= LFSR_SEED;
    end else if (load) begin
      cnt_q  <= 32'd0;
      lfsr_q <= LFSR_SEED;
    end else if (advance) begin
      cnt_q  <= cnt_q + 32'd1;
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign value = mode ? lfsr_q[DW-1:0] : cnt_q[DW-1:0];

endmodule

`default_nettype wire

// File: rtl/wb_sdr_traffic_gen.sv
// ==================================================================
// wb_sdr_traffic_gen : Wishbone B3 burst write / read-back checker master
// Optional ack watchdog: define TG_TIMEOUT_EN.   Rev 1.0
// ==================================================================
`timescale 1ns/1ps
`default_nettype none

module wb_sdr_traffic_gen
  import tg_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 26,
  parameter int BURST_MAX   = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_resetn,
  input  logic                           start,
  input  logic [AW-1:0]                  cfg_base_addr,
  input  logic [15:0]                    cfg_num_bursts,
  input  logic [$clog2(BURST_MAX):0]     cfg_burst_len,
  input  logic                           cfg_pattern,
  output logic                           busy,
  output logic                           done,
  output logic [15:0]                    err_count,
  output logic [AW-1:0]                  first_err_addr,
  output logic                           timeout,
  output logic                           wb_cyc_o,
  output logic                           wb_stb_o,
  output logic                           wb_we_o,
  output logic [AW-1:0]                  wb_addr_o,
  output logic [DW-1:0]                  wb_dat_o,
  output logic [DW/8-1:0]                wb_sel_o,
  output logic [2:0]                     wb_cti_o,
  input  logic [DW-1:0]                  wb_dat_i,
  input  logic                           wb_ack_i
);

  localparam int             BLW        = $clog2(BURST_MAX) + 1;
  localparam logic [AW-1:0]  STEP       = AW'(DW / 8);
  localparam logic [AW-1:0]  ALIGN_MASK = ~AW'(DW / 8 - 1);

  tg_state_e        state, state_nx;
  logic [AW-1:0]    base_q, addr_q;
  logic [15:0]      nb_q, burst_q;
  logic [BLW-1:0]   len_q, beat_q, len_clamped;
  logic             pat_q;
  logic [15:0]      err_q;
  logic [AW-1:0]    ferr_q;
  logic [DW-1:0]    pat_value;

  logic start_ok, stb_on, beat_ack, last_beat, last_burst, phase_switch;
  logic pat_load, rd_mismatch, timeout_hit;

  assign start_ok     = start && (state == IDLE || state == DONE);
  assign stb_on       = (state == WR) || (state == RD);
  assign beat_ack     = stb_on && wb_ack_i;
  assign last_beat    = (beat_q == len_q - BLW'(1));
  assign last_burst   = ((burst_q + 16'd1) == nb_q);
  assign phase_switch = (state == WR_GAP) && (burst_q == nb_q);
  assign pat_load     = start_ok || phase_switch;
  assign rd_mismatch  = (state == RD) && wb_ack_i && (wb_dat_i != pat_value);

  assign len_clamped = (cfg_burst_len == '0)              ? BLW'(1) :
                       (cfg_burst_len > BLW'(BURST_MAX))  ? BLW'(BURST_MAX) :
                                                            cfg_burst_len;

`ifdef TG_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0] wd_q;
  logic           to_q;

  // Counts consecutive stb-high cycles without an ack.
  always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
    if (!wb_resetn) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= (!stb_on || wb_ack_i) ? '0 : wd_q + WDW'(1);
      if (start_ok)         to_q <= 1'b0;
      else if (timeout_hit) to_q <= 1'b1;
    end
  end

  assign timeout_hit = stb_on && !wb_ack_i && (wd_q == WDW'(TIMEOUT_CYC - 1));
  assign timeout     = to_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

  tg_pattern_gen #(.DW(DW)) u_pattern (
    .clk     (wb_clk_i),
    .rst_n   (wb_resetn),
    .mode    (pat_q),
    .load    (pat_load),
    .advance (beat_ack),
    .value   (pat_value)
  );

  always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
    if (!wb_resetn) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_cti_o = CTI_CLASSIC;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = (cfg_num_bursts == 16'd0) ? DONE : WR;
      WR: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = 1'b1;
        wb_cti_o = last_beat ? CTI_EOB : CTI_INCR;
        busy     = 1'b1;
        if (timeout_hit)                state_nx = DONE;
        else if (wb_ack_i && last_beat) state_nx = WR_GAP;
      end
      WR_GAP: begin
        busy     = 1'b1;
        state_nx = (burst_q == nb_q) ? RD : WR;
      end
      RD: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_cti_o = last_beat ? CTI_EOB : CTI_INCR;
        busy     = 1'b1;
        if (timeout_hit)                state_nx = DONE;
        else if (wb_ack_i && last_beat) state_nx = last_burst ? DONE : RD_GAP;
      end
      RD_GAP: begin
        busy     = 1'b1;
        state_nx = RD;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nx = (cfg_num_bursts == 16'd0) ? DONE : WR;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
    if (!wb_resetn) begin
      base_q  <= '0;
      addr_q  <= '0;
      nb_q    <= 16'd0;
      burst_q <= 16'd0;
      len_q   <= '0;
      beat_q  <= '0;
      pat_q   <= 1'b0;
      err_q   <= 16'd0;
      ferr_q  <= '0;
    end else if (start_ok) begin
      base_q  <= cfg_base_addr & ALIGN_MASK;
      addr_q  <= cfg_base_addr & ALIGN_MASK;
      nb_q    <= cfg_num_bursts;
      burst_q <= 16'd0;
      len_q   <= len_clamped;
      beat_q  <= '0;
      pat_q   <= cfg_pattern;
      err_q   <= 16'd0;
      ferr_q  <= '0;
    end else if (phase_switch) begin
      // Read-back replays the written region from the start.
      addr_q  <= base_q;
      burst_q <= 16'd0;
    end else if (beat_ack) begin
      addr_q <= addr_q + STEP;
      if (last_beat) begin
        beat_q  <= '0;
        burst_q <= burst_q + 16'd1;
      end else begin
        beat_q <= beat_q + BLW'(1);
      end
      if (rd_mismatch) begin
        if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
        if (err_q == 16'd0)    ferr_q <= addr_q;
      end
    end
  end

  assign wb_addr_o      = addr_q;
  assign wb_dat_o       = (state == WR) ? pat_value : '0;
  assign wb_sel_o       = '1;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_sdr_traffic_gen.sv
// ==================================================================
// tb_wb_sdr_traffic_gen : directed bench with a beat-list model and memory slave
// Rev 1.0
// ==================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wb_sdr_traffic_gen;

  localparam int AW = 26;
  localparam int BM = 8;
`ifdef TG_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bit            act = 1'b0;
  logic          start_r = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [15:0]   cfg_nb = 16'd0;
  logic [3:0]    cfg_bl = 4'd0;
  logic          cfg_pat = 1'b0;

  logic          busy32, done32, to32, cyc32, stb32, we32, ack32;
  logic [15:0]   err32;
  logic [AW-1:0] ferr32, addr32;
  logic [31:0]   dato32, dati32;
  logic [3:0]    sel32;
  logic [2:0]    cti32;

  logic          busy8, done8, to8, cyc8, stb8, we8, ack8;
  logic [15:0]   err8;
  logic [AW-1:0] ferr8, addr8;
  logic [7:0]    dato8, dati8;
  logic [0:0]    sel8;
  logic [2:0]    cti8;

  logic          start32, start8, ack_r;
  logic [31:0]   rdata;

  assign start32 = start_r && !act;
  assign start8  = start_r && act;
  assign ack32   = ack_r && !act;
  assign ack8    = ack_r && act;
  assign dati32  = rdata;
  assign dati8   = rdata[7:0];

  wb_sdr_traffic_gen #(.DW(32), .AW(AW), .BURST_MAX(BM), .TIMEOUT_CYC(TO)) u_dut32 (
    .wb_clk_i(clk), .wb_resetn(rst_n), .start(start32),
    .cfg_base_addr(cfg_base), .cfg_num_bursts(cfg_nb), .cfg_burst_len(cfg_bl), .cfg_pattern(cfg_pat),
    .busy(busy32), .done(done32), .err_count(err32), .first_err_addr(ferr32), .timeout(to32),
    .wb_cyc_o(cyc32), .wb_stb_o(stb32), .wb_we_o(we32), .wb_addr_o(addr32), .wb_dat_o(dato32),
    .wb_sel_o(sel32), .wb_cti_o(cti32), .wb_dat_i(dati32), .wb_ack_i(ack32));

  wb_sdr_traffic_gen #(.DW(8), .AW(AW), .BURST_MAX(BM), .TIMEOUT_CYC(TO)) u_dut8 (
    .wb_clk_i(clk), .wb_resetn(rst_n), .start(start8),
    .cfg_base_addr(cfg_base), .cfg_num_bursts(cfg_nb), .cfg_burst_len(cfg_bl), .cfg_pattern(cfg_pat),
    .busy(busy8), .done(done8), .err_count(err8), .first_err_addr(ferr8), .timeout(to8),
    .wb_cyc_o(cyc8), .wb_stb_o(stb8), .wb_we_o(we8), .wb_addr_o(addr8), .wb_dat_o(dato8),
    .wb_sel_o(sel8), .wb_cti_o(cti8), .wb_dat_i(dati8), .wb_ack_i(ack8));

  // Views of whichever instance is currently being exercised.
  logic          v_cyc, v_stb, v_we, v_busy, v_done, v_to, v_sel_ok;
  logic [AW-1:0] v_addr, v_ferr;
  logic [31:0]   v_dat;
  logic [2:0]    v_cti;
  logic [15:0]   v_err;
  assign v_cyc    = act ? cyc8  : cyc32;
  assign v_stb    = act ? stb8  : stb32;
  assign v_we     = act ? we8   : we32;
  assign v_busy   = act ? busy8 : busy32;
  assign v_done   = act ? done8 : done32;
  assign v_to     = act ? to8   : to32;
  assign v_addr   = act ? addr8 : addr32;
  assign v_ferr   = act ? ferr8 : ferr32;
  assign v_dat    = act ? {24'h0, dato8} : dato32;
  assign v_cti    = act ? cti8  : cti32;
  assign v_err    = act ? err8  : err32;
  assign v_sel_ok = act ? (sel8 == 1'b1) : (sel32 == 4'hF);

  // Memory slave: one wait state per beat, optional bit-0 corruption on reads.
  logic [31:0]   mem [0:1023];
  bit            no_ack = 1'b0;
  bit            corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r <= 1'b0;
      rdata <= 32'h0;
    end else begin
      if (v_stb && ack_r && v_we) mem[v_addr[9:0]] <= v_dat;
      ack_r <= v_stb && !ack_r && !no_ack;
      rdata <= mem[v_addr[9:0]] ^ ((corrupt_en && v_addr == corrupt_addr) ? 32'h1 : 32'h0);
    end
  end

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [31:0]   dat;
    logic [2:0]    cti;
    int            gap;   // 0 = back-to-back, 1 = one idle cycle before, 2 = run start
  } beat_t;
  beat_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int beats_seen = 0;
  bit cyc_seen = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp_v);
    end
  endtask

  // Expected bus beats of a whole run, derived directly from the transaction rules.
  task automatic build(input int dw, input logic [AW-1:0] base, input int nb, input int bl, input bit pat);
    int            len, step;
    logic [AW-1:0] b0;
    logic [31:0]   mask, s;
    beat_t         e;
    len  = (bl == 0) ? 1 : ((bl > BM) ? BM : bl);
    step = dw / 8;
    b0   = base & ~AW'(step - 1);
    mask = (dw == 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
    exp_q.delete();
    for (int ph = 0; ph < 2; ph++) begin
      s = 32'hACE1_0001;
      for (int g = 0; g < nb * len; g++) begin
        e.we   = (ph == 0);
        e.addr = b0 + AW'(g * step);
        e.dat  = (pat ? s : 32'(g)) & mask;
        e.cti  = ((g % len) == len - 1) ? 3'b111 : 3'b010;
        e.gap  = (ph == 0 && g == 0) ? 2 : (((g % len) == 0) ? 1 : 0);
        exp_q.push_back(e);
        s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
      end
    end
  endtask

  // Compare process: every stb-high cycle is matched against the head beat.
  bit prev_stb = 1'b0;
  int low_cnt = 0;
  bit new_beat = 1'b1;
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      prev_stb = 1'b0;
      low_cnt  = 0;
      new_beat = 1'b1;
    end else begin
      if (v_stb) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got stb at addr 0x%0h, expected no bus activity", v_addr);
        end else begin
          e = exp_q[0];
          chk("beat_cyc", 64'(v_cyc), 64'(1));
          chk("beat_sel", 64'(v_sel_ok), 64'(1));
          chk("beat_we", 64'(v_we), 64'(e.we));
          chk("beat_addr", 64'(v_addr), 64'(e.addr));
          chk("beat_cti", 64'(v_cti), 64'(e.cti));
          if (e.we) chk("beat_wdata", 64'(v_dat), 64'(e.dat));
          if (new_beat && e.gap != 2) chk("beat_gap", 64'(low_cnt), 64'(e.gap));
          new_beat = 1'b0;
          if (ack_r) begin
            void'(exp_q.pop_front());
            beats_seen++;
            new_beat = 1'b1;
          end
        end
        low_cnt = 0;
      end else begin
        low_cnt++;
        if (v_cyc) chk("cyc_without_stb", 64'(v_cyc), 64'(0));
      end
      prev_stb = v_stb;
    end
  end

  always @(posedge clk) if (v_cyc) cyc_seen = 1'b1;

  task automatic pulse(input bit which, input logic [AW-1:0] base, input int nb, input int bl, input bit pat);
    @(negedge clk);
    act      = which;
    cfg_base = base;
    cfg_nb   = 16'(nb);
    cfg_bl   = 4'(bl);
    cfg_pat  = pat;
    start_r  = 1'b1;
    @(negedge clk);
    start_r  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_err, input logic [AW-1:0] exp_ferr);
    int n;
    n = 0;
    while (!v_done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL %s_done_wait: got done=0 after %0d cycles, expected done=1", tag, n);
    end
    chk({tag, "_done"}, 64'(v_done), 64'(1));
    chk({tag, "_busy"}, 64'(v_busy), 64'(0));
    chk({tag, "_err_count"}, 64'(v_err), 64'(exp_err));
    chk({tag, "_first_err_addr"}, 64'(v_ferr), 64'(exp_ferr));
    chk({tag, "_timeout"}, 64'(v_to), 64'(0));
    chk({tag, "_beats_left"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: got no finish, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int n, b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy32), 64'(0));
    chk("rst_done", 64'(done32), 64'(0));
    chk("rst_err", 64'(err32), 64'(0));
    chk("rst_ferr", 64'(ferr32), 64'(0));
    chk("rst_cyc", 64'(cyc32), 64'(0));
    chk("rst_stb", 64'(stb32), 64'(0));
    chk("rst_sel", 64'(sel32), 64'(4'hF));
    chk("rst_cti", 64'(cti32), 64'(0));
    chk("rst_addr", 64'(addr32), 64'(0));
    chk("rst_dat", 64'(dato32), 64'(0));
    chk("rst_timeout", 64'(to32), 64'(0));
    rst_n = 1'b1;

    // Zero bursts from IDLE: done in the next cycle, bus untouched.
    exp_q.delete();
    cyc_seen = 1'b0;
    pulse(1'b0, 26'h100, 0, 4, 1'b0);
    chk("nb0_done", 64'(v_done), 64'(1));
    chk("nb0_busy", 64'(v_busy), 64'(0));
    repeat (3) @(negedge clk);
    chk("nb0_no_cyc", 64'(cyc_seen), 64'(0));

    // 2 x 4 incrementing at 0x100.
    build(32, 26'h100, 2, 4, 1'b0);
    chk("model_len", 64'(exp_q.size()), 64'(16));
    chk("model_first_addr", 64'(exp_q[0].addr), 64'(26'h100));
    chk("model_last_waddr", 64'(exp_q[7].addr), 64'(26'h11C));
    chk("model_last_wdata", 64'(exp_q[7].dat), 64'(7));
    chk("model_cti_eob", 64'(exp_q[3].cti), 64'(3'b111));
    chk("model_cti_incr", 64'(exp_q[0].cti), 64'(3'b010));
    pulse(1'b0, 26'h100, 2, 4, 1'b0);
    chk("inc_busy_after_start", 64'(v_busy), 64'(1));
    chk("inc_cyc_after_start", 64'(v_cyc), 64'(1));
    chk("inc_done_cleared", 64'(v_done), 64'(0));
    wait_done("inc", 0, '0);

    // DW=8 LFSR, read beat 3 corrupted.
    corrupt_en   = 1'b1;
    corrupt_addr = 26'h203;
    build(8, 26'h200, 1, 8, 1'b1);
    chk("model_lfsr0", 64'(exp_q[0].dat), 64'(8'h01));
    chk("model_lfsr1", 64'(exp_q[1].dat), 64'(8'h03));
    pulse(1'b1, 26'h200, 1, 8, 1'b1);
    wait_done("lfsr8", 1, 26'h203);
    corrupt_en = 1'b0;

    // Burst length 0 becomes single beats; restart from DONE.
    build(32, 26'h040, 2, 0, 1'b0);
    chk("model_bl0_cti", 64'(exp_q[0].cti), 64'(3'b111));
    pulse(1'b0, 26'h040, 2, 0, 1'b0);
    wait_done("bl0", 0, '0);

    // Burst length 15 clamps to 8; unaligned base near the top wraps to 0.
    build(32, 26'h3FF_FFF2, 1, 15, 1'b1);
    chk("model_bl15_len", 64'(exp_q.size()), 64'(16));
    chk("model_wrap_first", 64'(exp_q[0].addr), 64'(26'h3FF_FFF0));
    chk("model_wrap_last", 64'(exp_q[7].addr), 64'(26'h00C));
    pulse(1'b0, 26'h3FF_FFF2, 1, 15, 1'b1);
    wait_done("bl15", 0, '0);

    // Reset during beat 2 of a write burst, then a clean run.
    build(32, 26'h100, 2, 4, 1'b0);
    pulse(1'b0, 26'h100, 2, 4, 1'b0);
    b0 = beats_seen;
    n  = 0;
    while (beats_seen < b0 + 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reached_beat2", 64'(beats_seen - b0), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc", 64'(cyc32), 64'(0));
    chk("rst_mid_stb", 64'(stb32), 64'(0));
    chk("rst_mid_busy", 64'(busy32), 64'(0));
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    build(32, 26'h180, 2, 4, 1'b1);
    pulse(1'b0, 26'h180, 2, 4, 1'b1);
    wait_done("after_rst", 0, '0);

`ifdef TG_TIMEOUT_EN
    // Slave never acks: stb must stay up for exactly TIMEOUT_CYC cycles.
    no_ack = 1'b1;
    build(32, 26'h500, 1, 1, 1'b0);
    pulse(1'b0, 26'h500, 1, 1, 1'b0);
    n = 0;
    while (v_stb && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("to_stb_cycles", 64'(n), 64'(16));
    chk("to_flag", 64'(v_to), 64'(1));
    chk("to_done", 64'(v_done), 64'(1));
    chk("to_cyc", 64'(v_cyc), 64'(0));
    chk("to_err_frozen", 64'(v_err), 64'(0));
    exp_q.delete();
    no_ack = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
